layer_out_serializer: RTL

//  Transmit side of the inter-layer neuron data stream. Captures a layer's parallel neuron

---
 rtl/layer_out_serializer_pkg.sv | 13 +
 rtl/layer_out_serializer.sv | 95 +++++++++
 2 files changed

// File: rtl/layer_out_serializer_pkg.sv
// Shared types and constants for the inter-layer neuron stream.
// The data width here is also used by the neuron blocks.
package layer_out_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } ser_state_t;

  localparam int DEFAULT_DATA_WIDTH = 16;

endpackage

// File: rtl/layer_out_serializer.sv
// Captures a layer's parallel neuron outputs and replays them one word per cycle,
// neuron 0 first, with at least one idle cycle between frames.
module layer_out_serializer
  import layer_out_serializer_pkg::*;
#(
  parameter int NUM_NEURON = 30,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           overrun
);

  localparam int CNT_W = $clog2(NUM_NEURON);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_NEURON - 1);

  ser_state_t             state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic [DATA_WIDTH-1:0]  hold [NUM_NEURON];
  logic                   accept;

  // A new frame is taken only when no frame is being emitted.
  assign accept   = in_valid && !rst && ((state == IDLE) || (state == GAP));
  assign cnt_next = cnt + CNT_W'(1);

  // Snapshot of the parallel outputs; deliberately left without reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NUM_NEURON; k++) begin
        hold[k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Frame FSM; cnt is the index of the beat currently on out_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        SEND: begin
          if (in_valid) begin
            overrun <= 1'b1;
          end
          if (cnt == LAST_IDX) begin
            state      <= GAP;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
          end else begin
            cnt        <= cnt_next;
            out_data   <= hold[cnt_next];
            frame_done <= (cnt_next == LAST_IDX);
          end
        end
        IDLE, GAP: begin
          frame_done <= 1'b0;
          if (in_valid) begin
            // First beat comes straight from the input so it lands one cycle after acceptance.
            state     <= SEND;
            cnt       <= '0;
            out_data  <= in_data[DATA_WIDTH-1:0];
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end else begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
